seq_datapath_primitives: RTL and testbench

- Bundles the three sequential-datapath primitives used by the iterative multiplier and divider in the ALU.
  - A free-running step counter.
  - A 4-way one-hot-free word multiplexer.
  - A 4-mode universal shift register.
- Each sub-function has an independent port group. All share one clock and one reset.
- The ALU's shift-and-add multiplier and restoring divider are built from these.

---
 rtl/seq_datapath_primitives.sv | 76 +++++++
 tb/tb_seq_datapath_primitives.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_datapath_primitives.sv
// Step counter, 4-way word mux and universal shift register
// shared by the iterative multiplier and divider.
module seq_datapath_primitives #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 r_n,
    output logic [CNT_WIDTH-1:0] cnt,
    input  logic                 sr_si,
    input  logic [1:0]           sr_ctrl,
    input  logic [WIDTH-1:0]     sr_d,
    output logic                 sr_so,
    output logic [WIDTH-1:0]     sr_q,
    input  logic [WIDTH-1:0]     mux_in0,
    input  logic [WIDTH-1:0]     mux_in1,
    input  logic [WIDTH-1:0]     mux_in2,
    input  logic [WIDTH-1:0]     mux_in3,
    input  logic [1:0]           mux_sel,
    output logic [WIDTH-1:0]     mux_out
);

    typedef enum logic [1:0] {
        SR_HOLD  = 2'b00,
        SR_LEFT  = 2'b01,
        SR_RIGHT = 2'b10,
        SR_LOAD  = 2'b11
    } sr_mode_e;

    sr_mode_e         sr_mode;
    logic [WIDTH-1:0] sr_nxt;

    assign sr_mode = sr_mode_e'(sr_ctrl);

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        sr_nxt = sr_q;
        unique case (sr_mode)
            SR_HOLD:  sr_nxt = sr_q;
            SR_LEFT:  sr_nxt = {sr_q[WIDTH-2:0], sr_si};
            SR_RIGHT: sr_nxt = {sr_si, sr_q[WIDTH-1:1]};
            SR_LOAD:  sr_nxt = sr_d;
            default:  sr_nxt = sr_q;
        endcase
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_nxt;
        end
    end

    // Pre-edge bit, so a chained register receives it on the same edge
    assign sr_so = (sr_mode == SR_LEFT) ? sr_q[WIDTH-1] : sr_q[0];

    always_comb begin
        mux_out = mux_in0;
        unique case (mux_sel)
            2'b00:   mux_out = mux_in0;
            2'b01:   mux_out = mux_in1;
            2'b10:   mux_out = mux_in2;
            2'b11:   mux_out = mux_in3;
            default: mux_out = mux_in0;
        endcase
    end

endmodule

// File: tb/tb_seq_datapath_primitives.sv
// Directed plus randomized checks of counter, shift register
// and mux against an arithmetic reference model.
module tb_seq_datapath_primitives;

    logic        clk;
    logic        r_n;
    logic [5:0]  cnt;
    logic        sr_si;
    logic [1:0]  sr_ctrl;
    logic [31:0] sr_d;
    logic        sr_so;
    logic [31:0] sr_q;
    logic [31:0] mux_in0, mux_in1, mux_in2, mux_in3;
    logic [1:0]  mux_sel;
    logic [31:0] mux_out;

    int errors = 0;
    int checks = 0;

    int          cnt_m;
    logic [31:0] sr_m;

    seq_datapath_primitives dut (
        .clk     (clk),
        .r_n     (r_n),
        .cnt     (cnt),
        .sr_si   (sr_si),
        .sr_ctrl (sr_ctrl),
        .sr_d    (sr_d),
        .sr_so   (sr_so),
        .sr_q    (sr_q),
        .mux_in0 (mux_in0),
        .mux_in1 (mux_in1),
        .mux_in2 (mux_in2),
        .mux_in3 (mux_in3),
        .mux_sel (mux_sel),
        .mux_out (mux_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mux_ref();
        logic [31:0] w [4];
        w[0] = mux_in0; w[1] = mux_in1; w[2] = mux_in2; w[3] = mux_in3;
        return w[mux_sel];
    endfunction

    function automatic logic so_ref();
        return (sr_ctrl == 2'd1) ? sr_m[31] : sr_m[0];
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".cnt"}, {26'd0, cnt}, cnt_m[31:0]);
        chk({tag, ".sr_q"}, sr_q, sr_m);
        chk({tag, ".sr_so"}, {31'd0, sr_so}, {31'd0, so_ref()});
        chk({tag, ".mux"}, mux_out, mux_ref());
    endtask

    // One rising edge: model advances from the pre-edge inputs
    task automatic step();
        logic [31:0] nxt;
        case (sr_ctrl)
            2'd0: nxt = sr_m;
            2'd1: nxt = (sr_m << 1) | {31'd0, sr_si};
            2'd2: nxt = (sr_m >> 1) | ({31'd0, sr_si} << 31);
            default: nxt = sr_d;
        endcase
        @(posedge clk);
        if (r_n) begin
            cnt_m = (cnt_m + 1) % 64;
            sr_m  = nxt;
        end
        #1;
    endtask

    task automatic async_reset(input string tag);
        r_n = 1'b0;
        #1;
        cnt_m = 0;
        sr_m  = '0;
        check_all(tag);
        r_n = 1'b1;
    endtask

    initial begin
        r_n = 1'b1; sr_si = 0; sr_ctrl = 0; sr_d = '0;
        mux_in0 = 32'h11111111; mux_in1 = 32'h22222222;
        mux_in2 = 32'h33333333; mux_in3 = 32'h44444444;
        mux_sel = 0;
        cnt_m = 0; sr_m = '0;
        #2;
        async_reset("rst0");

        for (int i = 1; i <= 64; i++) begin
            step();
            if (i == 31) chk("cnt31", {26'd0, cnt}, 32'd31);
            if (i == 64) chk("cnt_wrap", {26'd0, cnt}, 32'd0);
        end

        // Mid-operation reset with cnt=17 and a loaded word
        async_reset("rst1");
        for (int i = 1; i <= 17; i++) begin
            sr_ctrl = (i == 17) ? 2'd3 : 2'd0;
            sr_d = 32'hDEADBEEF;
            step();
        end
        chk("mid.cnt17", {26'd0, cnt}, 32'd17);
        chk("mid.q", sr_q, 32'hDEADBEEF);
        #2;
        async_reset("mid.rst");
        sr_ctrl = 2'd0;
        step();
        chk("mid.resume", {26'd0, cnt}, 32'd1);

        // Load then hold with toggling serial input
        sr_ctrl = 2'd3; sr_d = 32'h80000001;
        step();
        chk("load", sr_q, 32'h80000001);
        sr_ctrl = 2'd0;
        for (int i = 0; i < 3; i++) begin
            sr_si = ~sr_si;
            sr_d = $urandom;
            step();
            check_all("hold");
        end
        chk("hold.so", {31'd0, sr_so}, 32'd1);

        // Shift right
        sr_ctrl = 2'd2; sr_si = 0;
        #1;
        chk("sr.pre_so", {31'd0, sr_so}, 32'd1);
        step();
        chk("sr.q", sr_q, 32'h40000000);
        chk("sr.so", {31'd0, sr_so}, 32'd0);
        for (int i = 0; i < 31; i++) step();
        chk("sr.empty", sr_q, 32'd0);

        // Shift left
        sr_ctrl = 2'd3; sr_d = 32'h80000001;
        step();
        sr_ctrl = 2'd1; sr_si = 1;
        #1;
        chk("sl.pre_so", {31'd0, sr_so}, 32'd1);
        step();
        chk("sl.q", sr_q, 32'h00000003);
        sr_ctrl = 2'd2;
        #1;
        chk("sl.so_sw", {31'd0, sr_so}, 32'd1);
        sr_ctrl = 2'd1;
        #1;
        chk("sl.so_msb", {31'd0, sr_so}, 32'd0);

        // Mux sweep, including while reset is held
        for (int s = 0; s < 4; s++) begin
            mux_sel = s[1:0];
            #1;
            chk("mux", mux_out, 32'h11111111 * (s + 1));
        end
        r_n = 1'b0;
        cnt_m = 0; sr_m = '0;
        for (int s = 0; s < 4; s++) begin
            mux_sel = s[1:0];
            #1;
            chk("mux_rst", mux_out, 32'h11111111 * (s + 1));
        end
        step();
        check_all("held_rst");
        #2;
        r_n = 1'b1;

        // Randomized operation with occasional async reset pulses
        for (int i = 0; i < 300; i++) begin
            sr_ctrl = 2'($urandom_range(0, 3));
            sr_si   = 1'($urandom_range(0, 1));
            sr_d    = $urandom;
            mux_in0 = $urandom; mux_in1 = $urandom;
            mux_in2 = $urandom; mux_in3 = $urandom;
            mux_sel = 2'($urandom_range(0, 3));
            #1;
            check_all("rnd.pre");
            step();
            check_all("rnd.post");
            if ($urandom_range(0, 24) == 0) async_reset("rnd.rst");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
